// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and sizing for the cache-line <-> memory-burst adaptor.
package cacheline_adaptor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned DEF_S_LINE  = 256;
  localparam int unsigned DEF_S_BURST = 64;
  localparam int unsigned BEATS       = DEF_S_LINE / DEF_S_BURST;
  localparam int unsigned BEAT_IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cacheline_adaptor.sv
// Splits cache line reads/writes into fixed-length memory bursts, one beat per resp_i.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int unsigned S_LINE  = DEF_S_LINE,
  parameter int unsigned S_BURST = DEF_S_BURST
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [S_LINE-1:0]  line_i,
  output logic [S_LINE-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [S_BURST-1:0] burst_i,
  output logic [S_BURST-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int unsigned NB = S_LINE / S_BURST;
  localparam int unsigned IW = idx_width(NB);

  state_e              state_q, state_d;
  logic [IW-1:0]       beat_q, beat_d;
  logic [S_LINE-1:0]   buf_q, buf_d;
  logic [S_LINE-1:0]   line_q, line_d;
  logic [31:0]         addr_q, addr_d;
  logic [S_BURST-1:0]  burst_q, burst_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic                resp_q, resp_d;
  logic                last_beat;

  assign last_beat = (beat_q == IW'(NB - 1));

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    buf_d   = buf_q;
    line_d  = line_q;
    addr_d  = addr_q;

    unique case (state_q)
      IDLE: begin
        if (read_i) begin
          state_d = READ;
          addr_d  = address_i & ~32'h0000_001F;
          beat_d  = '0;
        end else if (write_i) begin
          state_d = WRITE;
          addr_d  = address_i & ~32'h0000_001F;
          buf_d   = line_i;
          beat_d  = '0;
        end
      end
      READ: begin
        if (resp_i) begin
          buf_d[beat_q*S_BURST +: S_BURST] = burst_i;
          if (last_beat) begin
            beat_d  = '0;
            state_d = DONE;
            // Publish the assembled line only on completion so line_o stays stable otherwise.
            line_d  = buf_d;
          end else begin
            beat_d = beat_q + IW'(1);
          end
        end
      end
      WRITE: begin
        if (resp_i) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + IW'(1);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    rd_d    = (state_d == READ);
    wr_d    = (state_d == WRITE);
    resp_d  = (state_d == DONE);
    burst_d = (state_d == WRITE) ? buf_d[beat_d*S_BURST +: S_BURST] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      buf_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      burst_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      buf_q   <= buf_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      burst_q <= burst_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      resp_q  <= resp_d;
    end
  end

  assign line_o    = line_q;
  assign address_o = addr_q;
  assign burst_o   = burst_q;
  assign read_o    = rd_q;
  assign write_o   = wr_q;
  assign resp_o    = resp_q;

endmodule
